// File: rtl/btn_debounce_pulse_pkg.sv
// ----------------------------------------------------------------------------
// btn_debounce_pulse_pkg
//   Shared definitions for the push-button conditioner:
//   - state_t : per-channel FSM encoding (3 bits)
//   - DEF_*   : default channel count, counter width and timing constants
//               (timing values assume a 25 MHz vgaclk)
//   - state_is_pressed : which states report a debounced "pressed" level
// ----------------------------------------------------------------------------
package btn_debounce_pulse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // released and stable
        ST_ARM  = 3'd1,   // press seen, waiting for it to stay stable
        ST_HELD = 3'd2,   // press accepted, waiting for first repeat
        ST_RPT  = 3'd3,   // auto-repeating while held
        ST_REL  = 3'd4    // release seen, waiting for it to stay stable
    } state_t;

    localparam int          DEF_NBTN          = 2;
    localparam int          DEF_CW            = 24;
    localparam int unsigned DEF_DEBOUNCE_CYC  = 500000;     // 20 ms
    localparam bit          DEF_REPEAT_EN     = 1'b1;
    localparam int unsigned DEF_REPEAT_DELAY  = 12500000;   // 0.5 s
    localparam int unsigned DEF_REPEAT_PERIOD = 5000000;    // 0.2 s

    // REL still reports pressed: the level only drops once the release
    // itself has been debounced.
    function automatic logic state_is_pressed(input state_t st);
        return (st == ST_HELD) || (st == ST_RPT) || (st == ST_REL);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// ----------------------------------------------------------------------------
// btn_debounce_pulse_if
//   Groups the button-side signals of btn_debounce_pulse.
//   btn_raw   : raw asynchronous button levels, 1 = pressed
//   btn_level : debounced level per channel, 1 = pressed
//   btn_pulse : one-cycle strobe per accepted press or auto-repeat
//   dbg_state : current FSM state of every channel (state_t encoding)
//   modport master : the side that owns the pins and consumes the strobes
//   modport slave  : the conditioner itself
//   There is no backpressure: btn_pulse is a fire-and-forget strobe, valid
//   for exactly one cycle, and the consumer must sample it on that cycle.
// ----------------------------------------------------------------------------
interface btn_debounce_pulse_if #(
    parameter int NBTN = 2
);
    logic [NBTN-1:0]       btn_raw;
    logic [NBTN-1:0]       btn_level;
    logic [NBTN-1:0]       btn_pulse;
    logic [NBTN-1:0][2:0]  dbg_state;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  dbg_state
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output dbg_state
    );
endinterface

// File: rtl/btn_debounce_pulse_debounce_chan.sv
// ----------------------------------------------------------------------------
// btn_debounce_pulse_debounce_chan
//   One button channel: 2-FF synchronizer, debounce/auto-repeat FSM and a
//   saturating timing counter.
//   clk       : sole clock
//   rst_n     : asynchronous active-low reset
//   raw       : asynchronous raw button level, 1 = pressed
//   level     : registered debounced level
//   pulse     : registered one-cycle strobe per accepted press / repeat
//   state_dbg : current FSM state
// ----------------------------------------------------------------------------
module btn_debounce_pulse_debounce_chan
    import btn_debounce_pulse_pkg::*;
#(
    parameter int            CW            = DEF_CW,
    parameter logic [CW-1:0] DEBOUNCE_CYC  = CW'(DEF_DEBOUNCE_CYC),
    parameter bit            REPEAT_EN     = DEF_REPEAT_EN,
    parameter logic [CW-1:0] REPEAT_DELAY  = CW'(DEF_REPEAT_DELAY),
    parameter logic [CW-1:0] REPEAT_PERIOD = CW'(DEF_REPEAT_PERIOD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    output logic       level,
    output logic       pulse,
    output logic [2:0] state_dbg
);

    // The counter starts at 0 on the cycle a state is entered, so the
    // decision is taken when it reaches the limit minus one.
    localparam logic [CW-1:0] DEB_LAST = DEBOUNCE_CYC  - CW'(1);
    localparam logic [CW-1:0] DLY_LAST = REPEAT_DELAY  - CW'(1);
    localparam logic [CW-1:0] PER_LAST = REPEAT_PERIOD - CW'(1);

    logic          sync1;
    logic          s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          cnt_clr;
    logic          pulse_nxt;
    logic          level_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            level <= level_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pulse_nxt = 1'b0;
        cnt_clr   = 1'b0;
        cnt_nxt   = cnt;

        case (state)
            ST_IDLE: begin
                if (s) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (!s) begin
                    state_nxt = ST_IDLE;          // glitch, silently dropped
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_HELD;
                    pulse_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_nxt = ST_REL;
                end else if (REPEAT_EN && (cnt == DLY_LAST)) begin
                    state_nxt = ST_RPT;
                    pulse_nxt = 1'b1;
                end
            end
            ST_RPT: begin
                if (!s) begin
                    state_nxt = ST_REL;
                end else if (cnt == PER_LAST) begin
                    pulse_nxt = 1'b1;
                    cnt_clr   = 1'b1;             // restart the period in place
                end
            end
            ST_REL: begin
                if (s) begin
                    state_nxt = ST_HELD;          // release bounce: back to held, no pulse
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Saturate rather than wrap so a long hold with repeat disabled can
        // never alias back onto a decision value.
        if ((state_nxt != state) || cnt_clr || (state == ST_IDLE)) begin
            cnt_nxt = '0;
        end else if (cnt != '1) begin
            cnt_nxt = cnt + CW'(1);
        end

        level_nxt = state_is_pressed(state_nxt);
    end

    assign state_dbg = state;

endmodule

// File: rtl/btn_debounce_pulse.sv
// ----------------------------------------------------------------------------
// btn_debounce_pulse
//   Turns NBTN raw push-buttons into clean synchronous press strobes with
//   optional auto-repeat while held. Each channel is independent; presses
//   on several buttons in the same cycle give strobes in the same cycle.
//   vgaclk : sole clock (25 MHz pixel clock)
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of btn_debounce_pulse_if
//            (btn_raw in, btn_level / btn_pulse / dbg_state out)
// ----------------------------------------------------------------------------
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int            NBTN          = DEF_NBTN,
    parameter int            CW            = DEF_CW,
    parameter logic [CW-1:0] DEBOUNCE_CYC  = CW'(DEF_DEBOUNCE_CYC),
    parameter bit            REPEAT_EN     = DEF_REPEAT_EN,
    parameter logic [CW-1:0] REPEAT_DELAY  = CW'(DEF_REPEAT_DELAY),
    parameter logic [CW-1:0] REPEAT_PERIOD = CW'(DEF_REPEAT_PERIOD)
) (
    input  logic                vgaclk,
    input  logic                rst_n,
    btn_debounce_pulse_if.slave bus
);

    logic [NBTN-1:0]      level_v;
    logic [NBTN-1:0]      pulse_v;
    logic [NBTN-1:0][2:0] state_v;

    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        btn_debounce_pulse_debounce_chan #(
            .CW            (CW),
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk       (vgaclk),
            .rst_n     (rst_n),
            .raw       (bus.btn_raw[i]),
            .level     (level_v[i]),
            .pulse     (pulse_v[i]),
            .state_dbg (state_v[i])
        );
    end

    assign bus.btn_level = level_v;
    assign bus.btn_pulse = pulse_v;
    assign bus.dbg_state = state_v;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
module tb_btn_debounce_pulse;
    import btn_debounce_pulse_pkg::*;

    localparam int NBTN = 2;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;

    // ---------------- clock / reset ----------------
    logic vgaclk = 1'b0;
    logic rst_n;
    logic [1:0] raw;

    always #5 vgaclk = ~vgaclk;

    btn_debounce_pulse_if #(.NBTN(NBTN)) bus_a ();
    btn_debounce_pulse_if #(.NBTN(NBTN)) bus_b ();

    assign bus_a.btn_raw = raw;
    assign bus_b.btn_raw = raw;

    btn_debounce_pulse #(
        .NBTN(NBTN), .CW(8), .DEBOUNCE_CYC(8'd4), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(8'd10), .REPEAT_PERIOD(8'd5)
    ) u_dut_a (
        .vgaclk(vgaclk), .rst_n(rst_n), .bus(bus_a)
    );

    btn_debounce_pulse #(
        .NBTN(NBTN), .CW(8), .DEBOUNCE_CYC(8'd4), .REPEAT_EN(1'b0),
        .REPEAT_DELAY(8'd10), .REPEAT_PERIOD(8'd5)
    ) u_dut_b (
        .vgaclk(vgaclk), .rst_n(rst_n), .bus(bus_b)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          pulses_a[2];
    int          pulses_b[2];
    int          split_a;
    int          falls_a0;
    int          fall_off;
    logic        lvl_seen_a0;
    logic        prev_lvl_a0;
    logic [1:0]  prev_pa;
    logic [1:0]  prev_pb;

    // ---------------- reference model ----------------
    // Works on run lengths of the synchronized input rather than on states:
    //   press accepted  when not pressed and s has been 1 for DEB+1 samples
    //   release accepted when pressed and s has been 0 for DEB+1 samples
    //   repeats at anchor+RD, anchor+RD+RP, ... while s stays 1, where the
    //   anchor is the accept cycle or the cycle s came back to 1 while pressed.
    // Index [v] : 0 = repeat enabled (dut a), 1 = repeat disabled (dut b).
    logic [1:0] m_p1, m_p2;
    int         ones_run[2];
    int         zeros_run[2];
    bit         m_lvl[2][2];
    int         m_anchor[2][2];
    logic [1:0] exp_level[2];
    logic [1:0] exp_pulse[2];

    task automatic model_reset();
        m_p1 = '0;
        m_p2 = '0;
        for (int c = 0; c < 2; c++) begin
            ones_run[c]  = 0;
            zeros_run[c] = 0;
        end
        for (int v = 0; v < 2; v++) begin
            exp_level[v] = '0;
            exp_pulse[v] = '0;
            for (int c = 0; c < 2; c++) begin
                m_lvl[v][c]    = 1'b0;
                m_anchor[v][c] = 0;
            end
        end
    endtask

    task automatic model_edge();
        logic [1:0] s;
        bit         rep_en;
        int         age;
        s    = m_p2;
        m_p2 = m_p1;
        m_p1 = raw;
        for (int c = 0; c < 2; c++) begin
            if (s[c]) begin
                ones_run[c]++;
                zeros_run[c] = 0;
            end else begin
                zeros_run[c]++;
                ones_run[c] = 0;
            end
        end
        for (int v = 0; v < 2; v++) begin
            rep_en = (v == 0);
            for (int c = 0; c < 2; c++) begin
                exp_pulse[v][c] = 1'b0;
                if (!m_lvl[v][c]) begin
                    if (s[c] && ones_run[c] >= DEB + 1) begin
                        m_lvl[v][c]     = 1'b1;
                        exp_pulse[v][c] = 1'b1;
                        m_anchor[v][c]  = cyc;
                    end
                end else if (s[c]) begin
                    if (ones_run[c] == 1) begin
                        m_anchor[v][c] = cyc;
                    end else begin
                        age = cyc - m_anchor[v][c];
                        if (rep_en && age >= RD && ((age - RD) % RP) == 0)
                            exp_pulse[v][c] = 1'b1;
                    end
                end else if (zeros_run[c] >= DEB + 1) begin
                    m_lvl[v][c] = 1'b0;
                end
                exp_level[v][c] = m_lvl[v][c];
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: advance, update the model, compare every output.
    task automatic step();
        @(posedge vgaclk);
        #1;
        cyc++;
        if (!rst_n) model_reset();
        else        model_edge();

        chk("level_a", 32'(bus_a.btn_level), 32'(exp_level[0]));
        chk("pulse_a", 32'(bus_a.btn_pulse), 32'(exp_pulse[0]));
        chk("level_b", 32'(bus_b.btn_level), 32'(exp_level[1]));
        chk("pulse_b", 32'(bus_b.btn_pulse), 32'(exp_pulse[1]));
        chk("no_back_to_back_a", 32'(bus_a.btn_pulse & prev_pa), 32'd0);
        chk("no_back_to_back_b", 32'(bus_b.btn_pulse & prev_pb), 32'd0);

        if (bus_a.btn_pulse[0]) obs_q.push_back(16'(cyc - base));
        for (int c = 0; c < 2; c++) begin
            if (bus_a.btn_pulse[c]) pulses_a[c]++;
            if (bus_b.btn_pulse[c]) pulses_b[c]++;
        end
        if (bus_a.btn_pulse == 2'b01 || bus_a.btn_pulse == 2'b10) split_a++;
        if (prev_lvl_a0 && !bus_a.btn_level[0]) begin
            falls_a0++;
            fall_off = cyc - base;
        end
        lvl_seen_a0 = lvl_seen_a0 | bus_a.btn_level[0];
        prev_lvl_a0 = bus_a.btn_level[0];
        prev_pa     = bus_a.btn_pulse;
        prev_pb     = bus_b.btn_pulse;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Start a directed scenario: the next clock edge is offset 0.
    task automatic start_scenario();
        base        = cyc + 1;
        exp_q.delete();
        obs_q.delete();
        pulses_a    = '{0, 0};
        pulses_b    = '{0, 0};
        split_a     = 0;
        falls_a0    = 0;
        fall_off    = -1;
        lvl_seen_a0 = 1'b0;
    endtask

    task automatic check_pulses(input string tag);
        int n;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_time"}, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int run_left[2];
        rst_n       = 1'b0;
        raw         = 2'b00;
        prev_pa     = '0;
        prev_pb     = '0;
        prev_lvl_a0 = 1'b0;
        model_reset();
        start_scenario();

        // reset state
        hold(3);
        chk("reset_level", 32'(bus_a.btn_level), 32'd0);
        chk("reset_pulse", 32'(bus_a.btn_pulse), 32'd0);
        chk("reset_state0", 32'(bus_a.dbg_state[0]), 32'(ST_IDLE));
        chk("reset_state1", 32'(bus_a.dbg_state[1]), 32'(ST_IDLE));
        rst_n = 1'b1;
        hold(3);

        // clean press, held 8 cycles
        start_scenario();
        raw = 2'b01; hold(8);
        raw = 2'b00; hold(20);
        exp_q = '{16'd6};
        check_pulses("clean");
        chk("clean_fall", 32'(fall_off), 32'd14);

        // glitch of 3 cycles
        start_scenario();
        raw = 2'b01; hold(3);
        raw = 2'b00; hold(12);
        check_pulses("glitch");
        chk("glitch_level", 32'(lvl_seen_a0), 32'd0);
        chk("glitch_state", 32'(bus_a.dbg_state[0]), 32'(ST_IDLE));

        // long hold with auto-repeat; raw falls at offset 39
        start_scenario();
        raw = 2'b01; hold(39);
        raw = 2'b00; hold(20);
        exp_q = '{16'd6, 16'd16, 16'd21, 16'd26, 16'd31, 16'd36};
        check_pulses("repeat");
        chk("repeat_b_single", 32'(pulses_b[0]), 32'd1);

        // release bounce 0-1-0 in 2-cycle steps; final stable 0 at offset 12
        start_scenario();
        raw = 2'b01; hold(8);
        raw = 2'b00; hold(2);
        raw = 2'b01; hold(2);
        raw = 2'b00; hold(20);
        exp_q = '{16'd6};
        check_pulses("bounce");
        chk("bounce_falls", 32'(falls_a0), 32'd1);
        chk("bounce_fall_time", 32'(fall_off), 32'(12 + 2 + DEB));

        // both buttons together
        start_scenario();
        raw = 2'b11; hold(39);
        raw = 2'b00; hold(20);
        exp_q = '{16'd6, 16'd16, 16'd21, 16'd26, 16'd31, 16'd36};
        check_pulses("both");
        chk("both_ch1_count", 32'(pulses_a[1]), 32'd6);
        chk("both_split", 32'(split_a), 32'd0);
        chk("both_b_ch0", 32'(pulses_b[0]), 32'd1);
        chk("both_b_ch1", 32'(pulses_b[1]), 32'd1);

        // reset while auto-repeating, button still held afterwards
        raw = 2'b01; hold(20);
        chk("pre_reset_state", 32'(bus_a.dbg_state[0]), 32'(ST_RPT));
        rst_n = 1'b0;
        #2;
        chk("async_reset_level", 32'(bus_a.btn_level), 32'd0);
        chk("async_reset_pulse", 32'(bus_a.btn_pulse), 32'd0);
        chk("async_reset_state", 32'(bus_a.dbg_state[0]), 32'(ST_IDLE));
        hold(2);
        rst_n = 1'b1;
        start_scenario();
        hold(12);
        exp_q = '{16'd6};
        check_pulses("after_reset");
        raw = 2'b00; hold(15);

        // randomized runs, with occasional reset pulses
        run_left = '{0, 0};
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (run_left[c] == 0) begin
                    raw[c]      = ~raw[c];
                    run_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40)
                                                             : $urandom_range(1, 7);
                end
                run_left[c]--;
            end
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst_n = 1'b1;
        raw   = 2'b00;
        hold(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
